// File: rtl/key_rs_driver.sv
// Two-key pushbutton front end: synchronise, debounce and arbitrate raw
// active-low SET/RESET keys into mutually exclusive s/r drive for an RS stage.
module key_rs_driver #(
    parameter int unsigned DEB_CYCLES = 240000,
    parameter int unsigned CNT_W      = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic key_s_n,
    input  logic key_r_n,
    output logic s,
    output logic r,
    output logic s_pulse,
    output logic r_pulse,
    output logic conflict
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SET,
        S_RST,
        S_BOTH
    } state_t;

    // Bit 0 carries the SET key, bit 1 the RESET key.
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [CNT_W-1:0] cnt [2];
    logic             pressed_s;
    logic             pressed_r;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '1;
            sync2  <= '1;
            deb    <= '1;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync1 <= {key_r_n, key_s_n};
            sync2 <= sync1;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pressed_s = ~deb[0];
    assign pressed_r = ~deb[1];

    // The first key to be pressed keeps ownership; the other key only takes
    // over once the owner releases, giving a direct handoff without IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (pressed_s && pressed_r) state_next = S_BOTH;
                else if (pressed_s)         state_next = S_SET;
                else if (pressed_r)         state_next = S_RST;
            end
            S_SET: begin
                if (!pressed_s) state_next = pressed_r ? S_RST : S_IDLE;
            end
            S_RST: begin
                if (!pressed_r) state_next = pressed_s ? S_SET : S_IDLE;
            end
            S_BOTH: begin
                if (!pressed_s && !pressed_r) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            s        <= 1'b0;
            r        <= 1'b0;
            s_pulse  <= 1'b0;
            r_pulse  <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state    <= state_next;
            s        <= (state_next == S_SET);
            r        <= (state_next == S_RST);
            s_pulse  <= (state_next == S_SET) && (state != S_SET);
            r_pulse  <= (state_next == S_RST) && (state != S_RST);
            conflict <= (state_next == S_BOTH);
        end
    end

endmodule

// File: tb/tb_key_rs_driver.sv
// Bench for key_rs_driver: directed scenarios plus random key activity, all
// outputs compared every cycle against a window-based behavioural model.
module tb_key_rs_driver;

    localparam int unsigned DEB = 4;

    logic clk = 1'b0;
    logic rst;
    logic key_s_n;
    logic key_r_n;
    logic s, r, s_pulse, r_pulse, conflict;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    key_rs_driver #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_s_n  (key_s_n),
        .key_r_n  (key_r_n),
        .s        (s),
        .r        (r),
        .s_pulse  (s_pulse),
        .r_pulse  (r_pulse),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    // Model: a key's debounced level flips once the last DEB synchronized
    // samples all disagree with it. Owner: 0 none, 1 set, 2 reset, 3 both.
    logic [1:0]     m_s1, m_s2, m_deb;
    logic [DEB-1:0] m_hist [2];
    int             m_owner;
    logic           e_s, e_r, e_sp, e_rp, e_c;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_s1 = '1; m_s2 = '1; m_deb = '1;
        m_hist[0] = '1; m_hist[1] = '1;
        m_owner = 0;
        {e_s, e_r, e_sp, e_rp, e_c} = '0;
    endtask

    task automatic model_step();
        int nxt;
        bit ps, pr;
        if (rst) begin
            model_reset();
            return;
        end
        ps  = !m_deb[0];
        pr  = !m_deb[1];
        nxt = m_owner;
        if (m_owner == 0)      nxt = (ps && pr) ? 3 : ps ? 1 : pr ? 2 : 0;
        else if (m_owner == 1) nxt = ps ? 1 : (pr ? 2 : 0);
        else if (m_owner == 2) nxt = pr ? 2 : (ps ? 1 : 0);
        else                   nxt = (ps || pr) ? 3 : 0;
        e_sp = (nxt == 1) && (m_owner != 1);
        e_rp = (nxt == 2) && (m_owner != 2);
        e_s  = (nxt == 1);
        e_r  = (nxt == 2);
        e_c  = (nxt == 3);
        m_owner = nxt;
        for (int i = 0; i < 2; i++) begin
            m_hist[i] = {m_hist[i][DEB-2:0], m_s2[i]};
            if (m_hist[i] == {DEB{~m_deb[i]}}) m_deb[i] = ~m_deb[i];
        end
        m_s2 = m_s1;
        m_s1 = {key_r_n, key_s_n};
    endtask

    task automatic check_all();
        check("s", s, e_s);
        check("r", r, e_r);
        check("s_pulse", s_pulse, e_sp);
        check("r_pulse", r_pulse, e_rp);
        check("conflict", conflict, e_c);
        check("exclusive", (s & r) | (s & conflict) | (r & conflict), 1'b0);
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        rst = 1'b1; key_s_n = 1'b1; key_r_n = 1'b1;
        model_reset();
        #1 check_all();
        tick(3);
        rst = 1'b0;
        tick(20);

        // single press and release
        key_s_n = 1'b0; tick(20);
        key_s_n = 1'b1; tick(12);

        // bouncing SET key never accepted
        for (int unsigned b = 0; b < 5; b++) begin
            key_s_n = 1'b0; tick(3);
            key_s_n = 1'b1; tick(1);
        end
        tick(12);

        // SET owns, RESET takes over on SET release
        key_s_n = 1'b0; tick(10);
        key_r_n = 1'b0; tick(10);
        key_s_n = 1'b1; tick(12);
        key_r_n = 1'b1; tick(12);

        // simultaneous press -> conflict until both released
        key_s_n = 1'b0; key_r_n = 1'b0; tick(12);
        key_r_n = 1'b1; tick(12);
        key_s_n = 1'b1; tick(12);

        // async reset while SET held, key re-debounced afterwards
        key_s_n = 1'b0; tick(10);
        @(posedge clk);
        model_step();
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        @(negedge clk);
        tick(2);
        rst = 1'b0;
        tick(12);
        key_s_n = 1'b1; tick(12);

        // random key activity
        for (int unsigned c = 0; c < 3000; c++) begin
            if ($urandom_range(39) == 0) begin
                key_s_n = 1'($urandom_range(1));
                key_r_n = key_s_n;
            end else begin
                if ($urandom_range(5) == 0) key_s_n = ~key_s_n;
                if ($urandom_range(5) == 0) key_r_n = ~key_r_n;
            end
            tick(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/key_rs_driver.md
# key_rs_driver

Front-end stage that turns two raw active-low pushbuttons (SET key, RESET key) into clean, mutually exclusive `s`/`r` drive for the RS flip-flop stage. Per key: 2-flop synchronizer, counter-based debouncer, then an arbitration FSM. The FSM guarantees `s` and `r` are never high together and flags a simultaneous press instead of driving the forbidden RS input state. Single-cycle press pulses are provided for counters/LEDs downstream.

## Interface
- `DEB_CYCLES`, default 240000: consecutive clk cycles a synchronized key must differ from its debounced state before the change is accepted (20 ms at 12 MHz); must be ≥ 2.
- `CNT_W`, default 18: debounce counter width; must hold `DEB_CYCLES-1`.
- `clk`  in  1  system clock; all flops on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `key_s_n`  in  1  SET pushbutton, asynchronous, low = pressed.
- `key_r_n`  in  1  RESET pushbutton, asynchronous, low = pressed.
- `s`  out  1  set drive to RS stage, registered.
- `r`  out  1  reset drive to RS stage, registered.
- `s_pulse`  out  1  one-cycle strobe on entry to SET.
- `r_pulse`  out  1  one-cycle strobe on entry to RST.
- `conflict`  out  1  both keys pressed with no owner, registered.

## Operation
- Synchronizer: per key, two flops; reset value 1 (released).
- Debouncer, per key:
  - `deb` flop (reset 1) and counter (reset 0).
  - Sync output == `deb` → counter cleared to 0.
  - Sync output != `deb` → counter increments.
  - On the edge where counter == `DEB_CYCLES-1` and the mismatch persists, `deb` takes the sync value and the counter clears.
  - Any shorter mismatch is discarded.
  - `pressed_x = ~deb_x`.
- FSM states, reset state IDLE:
  - IDLE: s-only pressed → SET. r-only pressed → RST. Both pressed on the same cycle → BOTH. None pressed → stay.
  - SET: stays while `pressed_s`; the first key to be pressed owns the output, so r pressed meanwhile is ignored. When `pressed_s` drops: go to RST if `pressed_r`, else IDLE.
  - RST: symmetric to SET.
  - BOTH: stays until both keys are released, then IDLE. Releasing only one key does not exit.
- Outputs are registered, updated on the same edge as the state:
  - `s` = SET, `r` = RST, `conflict` = BOTH.
  - `s_pulse` is high for exactly the one cycle after an edge that enters SET from any other state, including the direct RST→SET handoff. `r_pulse` likewise for RST.
  - No pulse on release or on entry to BOTH/IDLE.
- Invariant: `s & r` is never 1. At most one of `s`, `r`, `conflict` is high.

## Timing
- Reset (async assert): sync flops=1, `deb`=1, counters=0, state IDLE, `s`=`r`=`s_pulse`=`r_pulse`=`conflict`=0, immediately and while `rst` is held.
- Latency, key pin change settled before edge 1:
  - sync2 updates at edge 2.
  - `deb` updates at edge 2+`DEB_CYCLES`.
  - FSM and outputs update at edge 3+`DEB_CYCLES`.
  - Total: 3+`DEB_CYCLES` edges, for both press and release.
- Handoff SET→RST: `s` falls and `r` rises on the same edge, with no IDLE cycle in between. `r_pulse` is high that cycle.
- Key held through reset release: the key is treated as a new press, so it goes through the full debounce and the `s_pulse`/`r_pulse` fires.
- Key releases and re-presses before the debounce completes: counter clears, no output change.

## Test plan
All scenarios use `DEB_CYCLES`=4, so latency is 7 edges.
- Reset with keys released, then 20 idle cycles → all outputs 0 throughout.
- `key_s_n` low for 20 cycles, then high → `s`=1 after edge 7, `s_pulse` high for that single cycle, `r`=0. `s`=0 seven edges after release, with no pulse.
- `key_s_n` bounces (low 3 cycles / high 1 cycle, ×5), then stays high → `s` and `s_pulse` never assert.
- `key_s_n` pressed; 10 cycles later `key_r_n` pressed; 10 cycles later `key_s_n` released → `s`=1 with `r`=0 while both are held. Seven edges after the s release, `s` falls and `r`=1 on the same edge, with `r_pulse` high for one cycle.
- Both keys go low on the same cycle → `conflict`=1 after edge 7, `s`=`r`=0, no pulses. Release `key_r_n` → `conflict` stays 1. Release `key_s_n` → `conflict`=0 seven edges later, and `s` never pulses.
- `rst` asserted mid-cycle while in SET with `key_s_n` held → `s`=0 immediately. After `rst` deasserts, `s`=1 and `s_pulse` is high 7 edges later.
